// File: rtl/dmem_bus_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and the memory/peripheral decode.
// The arbiter connects through the slave modport; the masters and the memory side use master.
interface dmem_bus_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_wr;
  logic              m1_lock;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        owner;

  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wdata,
    output m0_gnt, m0_rdata,
    input  m1_req, m1_wr, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner
  );

  modport master (
    output m0_req, m0_wr, m0_addr, m0_wdata,
    input  m0_gnt, m0_rdata,
    output m1_req, m1_wr, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// Two-master data-memory bus arbiter: fixed priority to the CPU port (M0), with starvation
// protection and bounded locked bursts for the UART/DMA port (M1). Grants are same-cycle.
module dmem_bus_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned MAX_BURST  = 8
) (
  input logic       clk,
  input logic       reset,
  dmem_bus_if.slave bus
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic          lock_q;
  logic [1:0]    owner_q;

  logic gnt0_c;
  logic gnt1_c;
  logic burst_hold_c;
  logic starved_c;

  assign burst_hold_c = (state == OWN1) && bus.m1_req && lock_q && (burst_cnt < BW'(MAX_BURST));
  assign starved_c    = (starve_cnt == SW'(STARVE_MAX)) && bus.m1_req;

  // Priority: locked burst, starvation rescue, M0, M1; nothing granted while in reset.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (reset) begin
      if (burst_hold_c || starved_c) begin
        gnt1_c = 1'b1;
      end else if (bus.m0_req) begin
        gnt0_c = 1'b1;
      end else if (bus.m1_req) begin
        gnt1_c = 1'b1;
      end
    end
  end

  // Bus mux; an idle bus is driven to all zeros.
  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.m0_rdata  = '0;
    bus.m1_rdata  = '0;
    if (gnt0_c) begin
      bus.mem_rd    = ~bus.m0_wr;
      bus.mem_wr    = bus.m0_wr;
      bus.mem_addr  = bus.m0_addr;
      bus.mem_wdata = bus.m0_wdata;
      bus.m0_rdata  = bus.mem_rdata;
    end else if (gnt1_c) begin
      bus.mem_rd    = ~bus.m1_wr;
      bus.mem_wr    = bus.m1_wr;
      bus.mem_addr  = bus.m1_addr;
      bus.mem_wdata = bus.m1_wdata;
      bus.m1_rdata  = bus.mem_rdata;
    end
  end

  assign bus.m0_gnt = gnt0_c;
  assign bus.m1_gnt = gnt1_c;
  assign bus.owner  = owner_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      burst_cnt  <= '0;
      lock_q     <= 1'b0;
      owner_q    <= 2'b00;
    end else begin
      if (gnt0_c) begin
        state   <= OWN0;
        owner_q <= 2'b01;
      end else if (gnt1_c) begin
        state   <= OWN1;
        owner_q <= 2'b10;
      end else begin
        state   <= IDLE;
        owner_q <= 2'b00;
      end

      if (bus.m1_req && !gnt1_c) begin
        if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
      end else begin
        starve_cnt <= '0;
      end

      // Saturates at MAX_BURST so the lock stays ignored until M1 loses the bus once.
      if (gnt1_c) begin
        if (state != OWN1)                     burst_cnt <= BW'(1);
        else if (burst_cnt != BW'(MAX_BURST)) burst_cnt <= burst_cnt + BW'(1);
      end else begin
        burst_cnt <= '0;
      end

      lock_q <= gnt1_c & bus.m1_lock;
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Directed bench for dmem_bus_arbiter: a per-cycle reference model pushes expected bus
// outputs into a queue as stimulus is driven; they are popped and checked on the falling edge.
module tb_dmem_bus_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned MAX_BURST  = 8;

  typedef struct packed {
    logic        g0;
    logic        g1;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] r0;
    logic [31:0] r1;
    logic [1:0]  owner;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  dmem_bus_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];

  int   m_state  = 0;
  int   m_starve = 0;
  int   m_burst  = 0;
  bit   m_lock   = 1'b0;
  logic [1:0] m_owner = 2'b00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive after the rising edge, check on the falling edge, advance the model.
  task automatic step(input logic rst, input logic m0req, input logic m0wr,
                      input logic [31:0] m0a, input logic [31:0] m0d,
                      input logic m1req, input logic m1wr, input logic m1lock,
                      input logic [31:0] m1a, input logic [31:0] m1d,
                      input logic [31:0] rdata, output logic g0o, output logic g1o);
    exp_t e;
    exp_t p;
    bit   g0;
    bit   g1;
    @(posedge clk);
    #1;
    reset         = rst;
    bus.m0_req    = m0req;  bus.m0_wr = m0wr;  bus.m0_addr = m0a;  bus.m0_wdata = m0d;
    bus.m1_req    = m1req;  bus.m1_wr = m1wr;  bus.m1_lock = m1lock;
    bus.m1_addr   = m1a;    bus.m1_wdata = m1d;
    bus.mem_rdata = rdata;

    g0 = 1'b0;
    g1 = 1'b0;
    if (rst) begin
      if (m_state == 2 && m1req && m_lock && m_burst < int'(MAX_BURST)) g1 = 1'b1;
      else if (m_starve == int'(STARVE_MAX) && m1req)                  g1 = 1'b1;
      else if (m0req)                                                  g0 = 1'b1;
      else if (m1req)                                                  g1 = 1'b1;
    end
    e       = '0;
    e.g0    = g0;
    e.g1    = g1;
    e.owner = m_owner;
    if (g0) begin
      e.rd = ~m0wr; e.wr = m0wr; e.addr = m0a; e.wdata = m0d; e.r0 = rdata;
    end else if (g1) begin
      e.rd = ~m1wr; e.wr = m1wr; e.addr = m1a; e.wdata = m1d; e.r1 = rdata;
    end
    exp_q.push_back(e);

    @(negedge clk);
    p = exp_q.pop_front();
    check("m0_gnt",    64'(bus.m0_gnt),    64'(p.g0));
    check("m1_gnt",    64'(bus.m1_gnt),    64'(p.g1));
    check("mem_rd",    64'(bus.mem_rd),    64'(p.rd));
    check("mem_wr",    64'(bus.mem_wr),    64'(p.wr));
    check("mem_addr",  64'(bus.mem_addr),  64'(p.addr));
    check("mem_wdata", 64'(bus.mem_wdata), 64'(p.wdata));
    check("m0_rdata",  64'(bus.m0_rdata),  64'(p.r0));
    check("m1_rdata",  64'(bus.m1_rdata),  64'(p.r1));
    check("owner",     64'(bus.owner),     64'(p.owner));
    g0o = bus.m0_gnt;
    g1o = bus.m1_gnt;

    if (!rst) begin
      m_state = 0; m_starve = 0; m_burst = 0; m_lock = 1'b0; m_owner = 2'b00;
    end else begin
      m_state = g0 ? 1 : (g1 ? 2 : 0);
      m_owner = g0 ? 2'b01 : (g1 ? 2'b10 : 2'b00);
      if (m1req && !g1) m_starve = (m_starve == int'(STARVE_MAX)) ? m_starve : m_starve + 1;
      else              m_starve = 0;
      if (g1) m_burst = (m_burst == 0) ? 1 : ((m_burst >= int'(MAX_BURST)) ? m_burst : m_burst + 1);
      else    m_burst = 0;
      m_lock = g1 && m1lock;
    end
  endtask

  task automatic idle(output logic g0o, output logic g1o);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, g0o, g1o);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g0;
    logic g1;
    reset = 1'b0;
    bus.m0_req = 1'b1; bus.m0_wr = 1'b1; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b1; bus.m1_wr = 1'b0; bus.m1_lock = 1'b0;
    bus.m1_addr = '0;  bus.m1_wdata = '0; bus.mem_rdata = '0;
    repeat (2) @(posedge clk);

    // Reset held with both masters requesting; M0 wins the first cycle after release.
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 32'h4, 32'h11, 1'b1, 1'b1, 1'b0, 32'h8, 32'h22, 32'h0, g0, g1);
      check("reset_no_gnt", 64'({g0, g1, bus.mem_wr}), 64'(0));
      check("reset_owner",  64'(bus.owner), 64'(0));
    end
    step(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 32'h8, 32'h0, 32'h77, g0, g1);
    check("post_reset_m0", 64'({g0, g1}), 64'(2'b10));
    idle(g0, g1);

    // Collision: M0 write wins over M1 read.
    step(1'b1, 1'b1, 1'b1, 32'h10, 32'hA5, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, g0, g1);
    check("coll_addr", 64'(bus.mem_addr), 64'(32'h10));
    check("coll_wr",   64'({bus.mem_wr, bus.m0_gnt, bus.m1_gnt}), 64'(3'b110));
    idle(g0, g1);

    // Starvation: M1 wins exactly on the fifth contended cycle, then M0 resumes.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0,
           32'hC0DE0000 | 32'(i), g0, g1);
      check($sformatf("starve_g1_%0d", i), 64'(g1), 64'(i == 4));
    end
    idle(g0, g1);

    // Locked M1 burst against constant M0 traffic: 8 beats, forced release, later re-burst.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 1'b1, 32'h300 + 32'(i * 4), 32'h0,
           32'hB0000000 | 32'(i), g0, g1);
      check($sformatf("burst_g1_%0d", i), 64'(g1), 64'((i >= 4 && i <= 11) || i >= 16));
    end
    idle(g0, g1);

    // Same-cycle read return to M1.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h40000018, 32'h0, 32'h5A, g0, g1);
    check("rd_m1_rdata", 64'(bus.m1_rdata), 64'(32'h5A));
    check("rd_m0_rdata", 64'(bus.m0_rdata), 64'(0));
    check("rd_strobe",   64'(bus.mem_rd),   64'(1));

    // Idle bus is all zeros and ownership drops to none.
    idle(g0, g1);
    idle(g0, g1);
    check("idle_outs", 64'({bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.m0_gnt, bus.m1_gnt}), 64'(0));
    check("idle_owner", 64'(bus.owner), 64'(0));

    // Reset on the third beat of a locked write burst aborts it without a write strobe.
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h500, 32'hD0, 32'h0, g0, g1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h504, 32'hD1, 32'h0, g0, g1);
    check("burst_beat2", 64'(g1), 64'(1));
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h508, 32'hD2, 32'h0, g0, g1);
    check("rst_mid_burst_wr", 64'({bus.mem_wr, g1}), 64'(0));
    step(1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 1'b1, 1'b1, 1'b1, 32'h50C, 32'hD3, 32'h0, g0, g1);
    check("after_abort_m0", 64'({g0, g1}), 64'(2'b10));
    check("after_abort_owner", 64'(bus.owner), 64'(0));

    check("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
